freq_meas_scheduler: RTL

//  Sequences a single frequency_counter across up to 8 sample-clock sources.

---
 rtl/freq_meas_pkg.sv | 31 +++
 rtl/freq_meas_csr.sv | 87 ++++++++
 rtl/freq_meas_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared CSR addresses, FSM encoding and channel search
package freq_meas_pkg;

   localparam logic [3:0] ADDR_CTRL        = 4'd0;
   localparam logic [3:0] ADDR_STATUS      = 4'd1;
   localparam logic [3:0] ADDR_MASK        = 4'd2;
   localparam logic [3:0] ADDR_SWEEP_CNT   = 4'd3;
   localparam logic [3:0] ADDR_VALID       = 4'd4;
   localparam logic [3:0] ADDR_RESULT_BASE = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_SETTLE,
      ST_READ,
      ST_CAPTURE,
      ST_NEXT
   } state_t;

   // Lowest set mask bit at or above start; result is {found, index}.
   // Searching downward lets the lowest qualifying bit overwrite the others.
   function automatic logic [3:0] next_channel(input logic [7:0] mask, input logic [3:0] start);
      logic [3:0] pick;
      pick = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i] && (4'(i) >= start)) pick = {1'b1, 3'(i)};
      end
      return pick;
   endfunction

endpackage

// File: rtl/freq_meas_csr.sv
// rtl/freq_meas_csr.sv - slave register file, readback mux and sticky status bits
module freq_meas_csr
   import freq_meas_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic              busy,
   input  logic [2:0]        cur_ch,
   input  logic              cap_en,
   input  logic [31:0]       cap_data,
   input  logic              sweep_inc,
   input  logic              clr_single,
   output logic              run,
   output logic              single,
   output logic [NUM_CH-1:0] mask
);

   logic              sweep_done;
   logic [31:0]       sweep_cnt;
   logic [NUM_CH-1:0] valid;
   logic [31:0]       result [NUM_CH];
   logic [31:0]       rd_mux;
   logic              unused_wdata;

   assign unused_wdata = ^writedata;

   // Register updates; a sweep completion beats a same-cycle sweep_done clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         run        <= 1'b0;
         single     <= 1'b0;
         sweep_done <= 1'b0;
         sweep_cnt  <= 32'd0;
         valid      <= '0;
         mask       <= '1;
         for (int i = 0; i < NUM_CH; i++) result[i] <= 32'd0;
      end else begin
         if (clr_single) single <= 1'b0;
         if (write && address == ADDR_CTRL) begin
            run <= writedata[0];
            if (writedata[1] && !busy) single <= 1'b1;
         end
         if (write && address == ADDR_STATUS && writedata[1]) sweep_done <= 1'b0;
         if (sweep_inc) begin
            sweep_done <= 1'b1;
            sweep_cnt  <= sweep_cnt + 32'd1;
         end
         if (write && address == ADDR_MASK) mask <= writedata[NUM_CH-1:0];
         for (int i = 0; i < NUM_CH; i++) begin
            if (cap_en && cur_ch == 3'(i)) begin
               result[i] <= cap_data;
               valid[i]  <= 1'b1;
            end
         end
      end
   end

   // Readback selection; single is write-only and unmapped words read as zero.
   always_comb begin
      rd_mux = 32'd0;
      case (address)
         ADDR_CTRL:      rd_mux = {31'd0, run};
         ADDR_STATUS:    rd_mux = {21'd0, cur_ch, 6'd0, sweep_done, busy};
         ADDR_MASK:      rd_mux = 32'(mask);
         ADDR_SWEEP_CNT: rd_mux = sweep_cnt;
         ADDR_VALID:     rd_mux = 32'(valid);
         default:        rd_mux = 32'd0;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
         if (address == ADDR_RESULT_BASE + 4'(i)) rd_mux = result[i];
      end
   end

   // Registered read data, valid the cycle after the read strobe.
   always_ff @(posedge clk) begin
      if (reset) readdata <= 32'd0;
      else       readdata <= read ? rd_mux : 32'd0;
   end

endmodule

// File: rtl/freq_meas_scheduler.sv
// rtl/freq_meas_scheduler.sv - sweeps one frequency counter across muxed sample clocks
module freq_meas_scheduler
   import freq_meas_pkg::*;
#(
   parameter int  NUM_CH       = 4,
   parameter int  GATE_CYCLES  = 50000,
   parameter int  SETTLE_GATES = 2,
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [3:0]      csr_address,
   input  logic            csr_read,
   input  logic            csr_write,
   input  logic [31:0]     csr_writedata,
   output logic [31:0]     csr_readdata,
   output logic            csr_waitrequest,
   output logic [3:0]      m_address,
   output logic            m_read,
   input  logic [31:0]     m_readdata,
   input  logic            m_waitrequest,
   output logic [CH_W-1:0] clk_sel
);

   localparam int SETTLE_TOTAL = SETTLE_GATES * GATE_CYCLES;
   localparam int CNT_W        = (SETTLE_TOTAL > 1) ? $clog2(SETTLE_TOTAL) : 1;

   state_t            state_q, state_d;
   logic [2:0]        ch_q, ch_d;
   logic [CNT_W-1:0]  settle_q, settle_d;
   logic              run, single;
   logic [NUM_CH-1:0] mask;
   logic [7:0]        mask_ext;
   logic [3:0]        first_pick, next_pick;
   logic              cap_en, sweep_inc, clr_single, busy;

   assign csr_waitrequest = 1'b0;
   assign m_address       = 4'd0;
   assign busy            = (state_q != ST_IDLE);
   // The mux select follows the channel register, so it switches as SELECT is entered.
   assign clk_sel         = ch_q[CH_W-1:0];
   assign mask_ext        = 8'(mask);
   assign first_pick      = next_channel(mask_ext, 4'd0);
   assign next_pick       = next_channel(mask_ext, {1'b0, ch_q} + 4'd1);

   freq_meas_csr #(.NUM_CH(NUM_CH)) u_csr (
      .clk        (clk),
      .reset      (reset),
      .address    (csr_address),
      .read       (csr_read),
      .write      (csr_write),
      .writedata  (csr_writedata),
      .readdata   (csr_readdata),
      .busy       (busy),
      .cur_ch     (ch_q),
      .cap_en     (cap_en),
      .cap_data   (m_readdata),
      .sweep_inc  (sweep_inc),
      .clr_single (clr_single),
      .run        (run),
      .single     (single),
      .mask       (mask)
   );

   // FSM state, current channel and settle counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ch_q     <= 3'd0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         settle_q <= settle_d;
      end
   end

   // Sweep sequencing; the mask is only consulted in IDLE and NEXT.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      settle_d   = settle_q;
      m_read     = 1'b0;
      cap_en     = 1'b0;
      sweep_inc  = 1'b0;
      clr_single = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mask == '0) begin
               clr_single = 1'b1;
            end else if (run || single) begin
               ch_d    = first_pick[2:0];
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            settle_d = CNT_W'(SETTLE_TOTAL - 1);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == '0) state_d = ST_READ;
            else                settle_d = settle_q - CNT_W'(1);
         end
         ST_READ: begin
            m_read = 1'b1;
            if (!m_waitrequest) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            cap_en  = 1'b1;
            state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (next_pick[3]) begin
               if (run || single) begin
                  ch_d    = next_pick[2:0];
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               sweep_inc  = 1'b1;
               clr_single = 1'b1;
               if (run && first_pick[3]) begin
                  ch_d    = first_pick[2:0];
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
